// File: rtl/layer_io_sequencer_pkg.sv
// Shared types and helpers for the dense-layer stream sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package layer_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    CAPTURE,
    DRAIN
  } state_t;

  // Bit offset of word k inside a packed bus of FP_W-wide words
  // (word k lives at [FP_W*k + FP_W-1 : FP_W*k]); use with "+: FP_W".
  function automatic int word_lsb(input int k);
    return k * FP_W;
  endfunction

  // Exponent all-ones marks Inf or NaN.
  function automatic logic is_nonfinite(input logic [FP_W-1:0] w);
    return &w[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/layer_io_sequencer_if.sv
// Bundle of stream and parallel-bus signals between the sequencer and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready handshakes.
// Ports: in_* (input word stream), a_bus/n_bus (node-bank buses), out_* (output
// word stream), busy; nan_seen only when LAYER_IO_NAN_FLUSH_EN is defined.
interface layer_io_sequencer_if
  import layer_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int N_OUT = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [FP_W-1:0]         in_data;
  logic [FP_W*N_IN-1:0]    a_bus;
  logic [FP_W*N_OUT-1:0]   n_bus;
  logic                    out_valid;
  logic                    out_ready;
  logic [FP_W-1:0]         out_data;
  logic                    out_last;
  logic                    busy;
`ifdef LAYER_IO_NAN_FLUSH_EN
  logic                    nan_seen;
`endif

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, n_bus, out_ready,
    output in_ready, a_bus, out_valid, out_data, out_last, busy
`ifdef LAYER_IO_NAN_FLUSH_EN
    , output nan_seen
`endif
  );

  // Upstream/downstream/node-bank side.
  modport master (
    output in_valid, in_data, n_bus, out_ready,
    input  in_ready, a_bus, out_valid, out_data, out_last, busy
`ifdef LAYER_IO_NAN_FLUSH_EN
    , input nan_seen
`endif
  );

endinterface

// File: rtl/layer_io_sequencer_out_serializer.sv
// Snapshots the node-bank N-bus and streams it out one word per handshake.
// Latency: first word valid the cycle after the capture pulse.
// Backpressure: holds data/last while out_ready is low; never drops a word.
// Ports: i_capture (one-cycle snapshot strobe), i_n_bus, i_out_ready,
// o_out_valid/o_out_data/o_out_last, o_done (last-word handshake pulse),
// o_nan_seen only when LAYER_IO_NAN_FLUSH_EN is defined.
module layer_out_serializer
  import layer_pkg::*;
#(
  parameter int N_OUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_capture,
  input  logic [FP_W*N_OUT-1:0] i_n_bus,
  input  logic                  i_out_ready,
  output logic                  o_out_valid,
  output logic [FP_W-1:0]       o_out_data,
  output logic                  o_out_last,
  output logic                  o_done
`ifdef LAYER_IO_NAN_FLUSH_EN
  , output logic                o_nan_seen
`endif
);

  localparam int OUT_CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(N_OUT - 1);

  logic [FP_W-1:0]   r_cap [N_OUT];
  logic [OUT_CW-1:0] r_out_cnt;
  logic              r_out_valid;
  logic [FP_W-1:0]   w_cap_word [N_OUT];
  logic              w_last_word;
  logic              w_hs;
`ifdef LAYER_IO_NAN_FLUSH_EN
  logic              r_nan_seen;
  logic              w_any_nan;
`endif

  // Word selection for the snapshot; non-finite words are zeroed when flushing.
  always_comb begin
`ifdef LAYER_IO_NAN_FLUSH_EN
    w_any_nan = 1'b0;
`endif
    for (int j = 0; j < N_OUT; j++) begin
      w_cap_word[j] = i_n_bus[word_lsb(j) +: FP_W];
`ifdef LAYER_IO_NAN_FLUSH_EN
      if (is_nonfinite(w_cap_word[j])) begin
        w_cap_word[j] = '0;
        w_any_nan     = 1'b1;
      end
`endif
    end
  end

  assign w_last_word = (r_out_cnt == OUT_LAST);
  assign w_hs        = r_out_valid & i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) r_cap[j] <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
`ifdef LAYER_IO_NAN_FLUSH_EN
      r_nan_seen  <= 1'b0;
`endif
    end else if (i_capture) begin
      for (int j = 0; j < N_OUT; j++) r_cap[j] <= w_cap_word[j];
      r_out_cnt   <= '0;
      r_out_valid <= 1'b1;
`ifdef LAYER_IO_NAN_FLUSH_EN
      r_nan_seen  <= r_nan_seen | w_any_nan;
`endif
    end else if (w_hs) begin
      if (w_last_word) begin
        r_out_cnt   <= '0;
        r_out_valid <= 1'b0;
`ifdef LAYER_IO_NAN_FLUSH_EN
        // The final handshake is the LOAD re-entry point for the sequencer.
        r_nan_seen  <= 1'b0;
`endif
      end else begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_cap[r_out_cnt];
  // Counter idles at 0 between frames, so gate with valid to keep last low.
  assign o_out_last  = r_out_valid & w_last_word;
  assign o_done      = w_hs & w_last_word;
`ifdef LAYER_IO_NAN_FLUSH_EN
  assign o_nan_seen  = r_nan_seen;
`endif

endmodule

// File: rtl/layer_io_sequencer.sv
// Deserialises float32 activations onto the A-bus, waits a settle window, captures the N-bus and serialises it out.
// Latency: first output word N_IN+SETTLE_CYCLES+1 clocks after first accept; full frame adds N_OUT.
// Backpressure: in_ready low outside LOAD; DRAIN stalls indefinitely on out_ready low.
// Ports: clk, rst_n (async active-low), io (layer_io_sequencer_if.slave).
// Optional: define LAYER_IO_NAN_FLUSH_EN to zero Inf/NaN node outputs and raise io.nan_seen.
module layer_io_sequencer
  import layer_pkg::*;
#(
  parameter int N_IN          = 10,
  parameter int N_OUT         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  layer_io_sequencer_if.slave  io
);

  localparam int IN_CW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SET_CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(N_IN - 1);
  localparam logic [SET_CW-1:0] SET_LAST = SET_CW'(SETTLE_CYCLES - 1);

  state_t               r_state;
  logic [IN_CW-1:0]     r_in_cnt;
  logic [SET_CW-1:0]    r_settle_cnt;
  logic [FP_W*N_IN-1:0] r_a_bus;
  logic                 r_in_ready;

  logic                 w_accept;
  logic                 w_capture;
  logic                 w_drain_done;
  logic                 w_out_valid;
  logic [FP_W-1:0]      w_out_data;
  logic                 w_out_last;
`ifdef LAYER_IO_NAN_FLUSH_EN
  logic                 w_nan_seen;
`endif

  assign w_accept  = (r_state == LOAD) & r_in_ready & io.in_valid;
  assign w_capture = (r_state == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_in_cnt     <= '0;
      r_settle_cnt <= '0;
      r_a_bus      <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          // in_ready rises the first clock after reset release.
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a_bus[word_lsb(int'(r_in_cnt)) +: FP_W] <= io.in_data;
            if (r_in_cnt == IN_LAST) begin
              r_in_cnt     <= '0;
              r_settle_cnt <= '0;
              r_in_ready   <= 1'b0;
              r_state      <= SETTLE;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          // A-bus is frozen here so the combinational node bank can resolve.
          if (r_settle_cnt == SET_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_in_ready <= 1'b1;
            r_state    <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  layer_out_serializer #(
    .N_OUT (N_OUT)
  ) u_out_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_capture   (w_capture),
    .i_n_bus     (io.n_bus),
    .i_out_ready (io.out_ready),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data),
    .o_out_last  (w_out_last),
    .o_done      (w_drain_done)
`ifdef LAYER_IO_NAN_FLUSH_EN
    , .o_nan_seen (w_nan_seen)
`endif
  );

  assign io.in_ready  = r_in_ready;
  assign io.a_bus     = r_a_bus;
  assign io.out_valid = w_out_valid;
  assign io.out_data  = w_out_data;
  assign io.out_last  = w_out_last;
  assign io.busy      = !((r_state == LOAD) && (r_in_cnt == '0));
`ifdef LAYER_IO_NAN_FLUSH_EN
  assign io.nan_seen  = w_nan_seen;
`endif

endmodule

// File: tb/tb_layer_io_sequencer.sv
// Scoreboard bench for layer_io_sequencer: directed frames, monitor pops expected words.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and in_valid held across frame boundaries.
module tb_layer_io_sequencer;

  localparam int N_IN   = 10;
  localparam int N_OUT  = 16;
  localparam int SETTLE = 4;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_io_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) io ();

  layer_io_sequencer #(
    .N_IN          (N_IN),
    .N_OUT         (N_OUT),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   acc_cnt = 0;
  int   lat_start = -1;
  bit   lat_arm = 1'b0;
  bit   lat_first_done = 1'b0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  initial begin
    bit          holding;
    logic [31:0] hold_d;
    logic        hold_l;
    exp_t        e;
    holding = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          chk("stall_valid", 32'(io.out_valid), 32'd1);
          chk("stall_data", io.out_data, hold_d);
          chk("stall_last", 32'(io.out_last), 32'(hold_l));
        end
        holding = 1'b0;
        if (io.in_valid && io.in_ready) begin
          acc_cnt++;
          if (lat_arm && lat_start < 0) lat_start = cyc;
        end
        if (io.out_valid) begin
          if (lat_arm && lat_start >= 0 && !lat_first_done) begin
            chk("first_out_latency", 32'(cyc - lat_start), 32'(N_IN + SETTLE + 1));
            lat_first_done = 1'b1;
          end
          if (io.out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: got %h expected no word", io.out_data);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", io.out_data, e.d);
              chk("out_last", 32'(io.out_last), 32'(e.l));
            end
            if (lat_arm && io.out_last) begin
              chk("frame_len", 32'(cyc - lat_start), 32'(N_IN + SETTLE + N_OUT));
              lat_arm = 1'b0;
            end
          end else begin
            holding = 1'b1;
            hold_d  = io.out_data;
            hold_l  = io.out_last;
          end
        end
      end
    end
  end

  // Drives the node-bank outputs and queues the words the DUT must emit.
  task automatic load_nbus(input logic [31:0] base, input bit nan3);
    exp_t e;
    for (int j = 0; j < N_OUT; j++) begin
      logic [31:0] w;
      w = (nan3 && j == 3) ? 32'h7FC00000 : base + 32'(j);
      io.n_bus[32*j +: 32] = w;
`ifdef LAYER_IO_NAN_FLUSH_EN
      e.d = (nan3 && j == 3) ? 32'h0 : w;
`else
      e.d = w;
`endif
      e.l = (j == N_OUT - 1);
      exp_q.push_back(e);
    end
  endtask

  // Presents one word and returns #1 after the edge that accepted it; in_valid stays high.
  task automatic send_word(input logic [31:0] d);
    int t;
    io.in_valid = 1'b1;
    io.in_data  = d;
    t = 0;
    @(negedge clk);
    while (!io.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_accept_timeout: got in_ready=0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] base, input bit gaps, input bit hold);
    for (int k = 0; k < N_IN; k++) begin
      send_word(base + 32'(k));
      if (gaps && (k % 2 == 0) && k != N_IN - 1) begin
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    if (!hold) io.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || io.out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d words pending, expected 0", tag, exp_q.size());
    end
    chk({tag, "_idle_in_ready"}, 32'(io.in_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(io.busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    while (hs_cnt < target && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL hs_wait_timeout: got %0d handshakes, expected %0d", hs_cnt, target);
    end
  endtask

  initial begin
    int h0;
    int a0;
    int t;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.n_bus     = '0;
    io.out_ready = 1'b1;
    rst_n        = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_data", io.out_data, 32'd0);
    chk("rst_out_last", 32'(io.out_last), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_a_bus", 32'(|io.a_bus), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);

    // Basic frame with latency measurement.
    load_nbus(32'h40000000, 1'b0);
    h0 = hs_cnt;
    lat_start = -1;
    lat_first_done = 1'b0;
    lat_arm = 1'b1;
    send_frame(32'h3F800000, 1'b0, 1'b0);
    chk("settle_in_ready", 32'(io.in_ready), 32'd0);
    chk("settle_busy", 32'(io.busy), 32'd1);
    wait_drain("basic");
    chk("basic_hs", 32'(hs_cnt - h0), 32'd16);

    // Input stalls: words must land in order on the A-bus.
    load_nbus(32'h41000000, 1'b0);
    send_frame(32'h3F000000, 1'b1, 1'b0);
    for (int k = 0; k < N_IN; k++)
      chk("a_bus_word", io.a_bus[32*k +: 32], 32'h3F000000 + 32'(k));
    chk("stall_in_ready", 32'(io.in_ready), 32'd0);
    wait_drain("install");

    // Output backpressure for 5 cycles mid-drain.
    load_nbus(32'h42000000, 1'b0);
    h0 = hs_cnt;
    send_frame(32'h3E000000, 1'b0, 1'b0);
    wait_hs(h0 + 5);
    #1;
    io.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_hs", 32'(hs_cnt - h0), 32'd16);

    // Back-to-back frames with in_valid held across the boundary.
    load_nbus(32'h43000000, 1'b0);
    h0 = hs_cnt;
    a0 = acc_cnt;
    send_frame(32'h3D000000, 1'b0, 1'b1);
    io.in_data = 32'h3C000000;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_no_early_accept", 32'(acc_cnt - a0), 32'd10);
    chk("b2b_in_ready_low", 32'(io.in_ready), 32'd0);
    load_nbus(32'h44000000, 1'b0);
    send_frame(32'h3C000000, 1'b0, 1'b0);
    wait_drain("b2b");
    chk("b2b_hs", 32'(hs_cnt - h0), 32'd32);
    chk("b2b_a_bus_w0", io.a_bus[31:0], 32'h3C000000);

    // Reset in the middle of DRAIN, after the 7th word.
    load_nbus(32'h45000000, 1'b0);
    h0 = hs_cnt;
    send_frame(32'h3B000000, 1'b0, 1'b0);
    wait_hs(h0 + 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(io.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("mid_rst_hs", 32'(hs_cnt - h0), 32'd7);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("after_rst_busy", 32'(io.busy), 32'd0);
    load_nbus(32'h46000000, 1'b0);
    h0 = hs_cnt;
    send_frame(32'h3A000000, 1'b0, 1'b0);
    wait_drain("post_rst");
    chk("post_rst_hs", 32'(hs_cnt - h0), 32'd16);

    // NaN on node output 3.
    load_nbus(32'h47000000, 1'b1);
    send_frame(32'h39000000, 1'b0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!io.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL nan_out_timeout: got out_valid=0, expected 1");
    end
`ifdef LAYER_IO_NAN_FLUSH_EN
    chk("nan_seen_set", 32'(io.nan_seen), 32'd1);
`endif
    wait_drain("nan");
`ifdef LAYER_IO_NAN_FLUSH_EN
    chk("nan_seen_clear", 32'(io.nan_seen), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_io_sequencer.md
Name: layer_io_sequencer

Overview:
- Streaming front/back end for one combinational dense layer (bank of float_mult/float_adder neuron nodes with ReLU).
- Deserialises an incoming stream of IEEE-754 single-precision activations into the parallel A-bus that drives the node bank.
- Holds the A-bus stable for a fixed settle window, snapshots the node-bank N-bus, then serialises the results out to the next layer.
- One frame = N_IN words in, N_OUT words out.

Parameters:
- N_IN, 10, words per input frame (width of node fan-in)
- N_OUT, 16, node outputs per frame
- SETTLE_CYCLES, 4, clocks the A-bus is held before N-bus capture (combinational chain budget); must be >= 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts input word
- in_data  input  32  input activation (float32)
- a_bus  output  32*N_IN  parallel activations to node bank, word k at bits [32k+31:32k]
- n_bus  input  32*N_OUT  parallel node-bank outputs, same packing
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts output word
- out_data  output  32  output activation (float32)
- out_last  output  1  high with final word (index N_OUT-1) of a frame
- busy  output  1  high in any state except LOAD with zero words collected

Behaviour:
- Reset (async assert, sync-clean deassert): state=LOAD, in_cnt=0, out_cnt=0, settle_cnt=0, a_bus=0, capture regs=0, in_ready=0 during reset then 1, out_valid=0, out_data=0, out_last=0, busy=0.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, in_data is written to a_bus word in_cnt and in_cnt increments.
  - On the accept of word N_IN-1: in_cnt->0, settle_cnt->0, next state SETTLE.
- SETTLE:
  - in_ready=0; a_bus is held unchanged.
  - settle_cnt increments each clock; at settle_cnt==SETTLE_CYCLES-1, next state CAPTURE.
- CAPTURE:
  - One cycle; all N_OUT words of n_bus are registered into the capture array.
  - out_cnt->0, next state DRAIN.
- DRAIN:
  - out_valid=1; out_data=capture[out_cnt]; out_last=(out_cnt==N_OUT-1).
  - On out_valid&out_ready, out_cnt increments.
  - On the handshake of the last word: out_valid drops next cycle, state returns to LOAD.
  - out_data/out_last are stable while out_valid=1 and out_ready=0.
- Latency:
  - First output word is valid N_IN + SETTLE_CYCLES + 1 clocks after the first input accept, with no input stalls.
  - Full frame, no stalls: N_IN + SETTLE_CYCLES + 1 + N_OUT clocks.
- No overlap: input is not accepted during SETTLE, CAPTURE or DRAIN. a_bus keeps the last frame until overwritten word-by-word in the next LOAD.
- Boundaries:
  - in_valid held high across the frame boundary: the word after word N_IN-1 is not accepted until LOAD re-entry.
  - out_ready low indefinitely: block holds in DRAIN and never drops data.
  - in_valid while in_ready=0: ignored.
  - Reset mid-frame from any state: immediate return to reset values; partial frame is discarded.
  - N_OUT==1: out_last is high on the only word.

Optional Feature:
- Macro LAYER_IO_NAN_FLUSH_EN.
- Defined: at CAPTURE, any n_bus word with exponent==8'hFF (Inf/NaN) is stored as 32'd0, and a sticky output flag port nan_seen (1 bit) is set. nan_seen clears only on reset or at LOAD re-entry.
- Undefined: words are captured verbatim and the nan_seen port does not exist.

Decomposition:
- Shared package layer_pkg holds:
  - FP_W=32 and EXP_MSB/EXP_LSB=30/23
  - state enum {LOAD, SETTLE, CAPTURE, DRAIN}
  - a function for word-slice extraction from the packed bus.
- One natural sub-module: layer_out_serializer (capture array + DRAIN handshake, out_cnt, out_last). The top keeps the LOAD/SETTLE control and a_bus registers.

Test Plan:
- Basic frame:
  - Stimulus: feed words 32'h3F800000 + k for k=0..9; tie n_bus word j to 32'h40000000 + j; out_ready=1.
  - Required: out_data sequence 32'h40000000..32'h4000000F; out_last only on the 16th word; first out_valid 15 clocks after the first accept.
- Input stalls: toggle in_valid 1-0-1 across the frame -> a_bus words land in order; SETTLE starts only after the 10th accept.
- Output backpressure:
  - Stimulus: out_ready low for 5 cycles mid-drain.
  - Required: out_data/out_last held constant during the stall; no word lost or duplicated; total 16 handshakes.
- Back-to-back frames with in_valid held high: the 11th word is not accepted until LOAD re-entry; the second frame's outputs reflect updated n_bus.
- Reset mid-DRAIN: assert rst_n=0 after word 7.
  - Required: out_valid=0 immediately, in_ready=1 after release, busy=0.
  - A new frame then completes normally.
- NaN flush:
  - With LAYER_IO_NAN_FLUSH_EN: n_bus word 3 = 32'h7FC00000 -> out word 3 = 0, nan_seen=1.
  - Without the macro: 32'h7FC00000 is passed through unchanged.
